// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the multi-buffer frame store.
package frame_buf_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FILL,
        WR_STALL
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_t;

    // Index width for n buffers; a single buffer still gets one bit.
    function automatic int buf_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_buf_ring_ram.sv
// Simple dual-port frame bank: synchronous write, registered read with one cycle latency.
module frame_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register holds its value between issued reads; only it is reset, never the array.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_buf_ring.sv
// Ring of NUM_BUFS frame buffers: producer fills in ring order, consumer drains in the same order.
module frame_buf_ring
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int FRAME_WORDS = 1 << ADDR_WIDTH,
    parameter int NUM_BUFS    = 2,
    parameter int BUF_W       = buf_w(NUM_BUFS)
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_frame_done,
    input  logic                  rd_req,
    output logic                  rd_avail,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic [BUF_W:0]        full_cnt,
    output logic                  ovf
);

    localparam int                    RAM_DEPTH = NUM_BUFS * (1 << ADDR_WIDTH);
    localparam int                    RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [BUF_W-1:0]      LAST_BUF  = BUF_W'(NUM_BUFS - 1);
    localparam logic [BUF_W:0]        BUFS      = (BUF_W + 1)'(NUM_BUFS);

    wr_state_t             wr_state_q, wr_state_d;
    rd_state_t             rd_state_q, rd_state_d;
    logic [BUF_W-1:0]      wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [BUF_W:0]        full_cnt_q, full_cnt_d;
    logic                  wr_frame_done_q, wr_frame_done_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic                  ovf_q, ovf_d;

    logic wr_accept, wr_commit, rd_issue, rd_release;

    // Both flags come from full_cnt alone, so neither sees wr_valid or rd_req combinationally.
    assign wr_ready = (full_cnt_q < BUFS);
    assign rd_avail = (full_cnt_q != '0);

    assign wr_accept  = wr_valid && wr_ready;
    assign wr_commit  = wr_accept && (wr_addr_q == LAST_ADDR);
    assign rd_issue   = rd_req && ((rd_state_q == RD_READ) || rd_avail);
    assign rd_release = rd_issue && (rd_addr_q == LAST_ADDR);

    always_comb begin
        wr_state_d      = wr_state_q;
        rd_state_d      = rd_state_q;
        wr_buf_d        = wr_buf_q;
        wr_addr_d       = wr_addr_q;
        rd_buf_d        = rd_buf_q;
        rd_addr_d       = rd_addr_q;
        full_cnt_d      = full_cnt_q;
        wr_frame_done_d = wr_commit;
        rd_valid_d      = rd_issue;
        rd_last_d       = rd_release;
        ovf_d           = ovf_q | (wr_valid && !wr_ready);

        if (wr_accept) begin
            wr_addr_d = wr_commit ? '0 : wr_addr_q + 1'b1;
        end
        if (wr_commit) begin
            wr_buf_d = (wr_buf_q == LAST_BUF) ? '0 : wr_buf_q + 1'b1;
        end
        if (rd_issue) begin
            rd_addr_d = rd_release ? '0 : rd_addr_q + 1'b1;
        end
        if (rd_release) begin
            rd_buf_d = (rd_buf_q == LAST_BUF) ? '0 : rd_buf_q + 1'b1;
        end

        // A commit and a release on the same edge cancel out in the count.
        case ({wr_commit, rd_release})
            2'b10:   full_cnt_d = full_cnt_q + 1'b1;
            2'b01:   full_cnt_d = full_cnt_q - 1'b1;
            default: full_cnt_d = full_cnt_q;
        endcase

        case (wr_state_q)
            WR_IDLE: begin
                if (wr_commit) begin
                    wr_state_d = WR_IDLE;
                end else if (wr_accept) begin
                    wr_state_d = WR_FILL;
                end else if (full_cnt_q == BUFS) begin
                    wr_state_d = WR_STALL;
                end
            end
            WR_FILL: begin
                if (wr_commit) begin
                    wr_state_d = WR_IDLE;
                end
            end
            WR_STALL: begin
                if (full_cnt_q < BUFS) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        case (rd_state_q)
            RD_IDLE: begin
                if (rd_issue && !rd_release) begin
                    rd_state_d = RD_READ;
                end
            end
            RD_READ: begin
                if (rd_release) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_state_q      <= WR_IDLE;
            rd_state_q      <= RD_IDLE;
            wr_buf_q        <= '0;
            wr_addr_q       <= '0;
            rd_buf_q        <= '0;
            rd_addr_q       <= '0;
            full_cnt_q      <= '0;
            wr_frame_done_q <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_last_q       <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            wr_state_q      <= wr_state_d;
            rd_state_q      <= rd_state_d;
            wr_buf_q        <= wr_buf_d;
            wr_addr_q       <= wr_addr_d;
            rd_buf_q        <= rd_buf_d;
            rd_addr_q       <= rd_addr_d;
            full_cnt_q      <= full_cnt_d;
            wr_frame_done_q <= wr_frame_done_d;
            rd_valid_q      <= rd_valid_d;
            rd_last_q       <= rd_last_d;
            ovf_q           <= ovf_d;
        end
    end

    frame_bank_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (RAM_DEPTH),
        .AW        (RAM_AW)
    ) u_ram (
        .clk    (wr_clk),
        .reset  (reset),
        .wr_en  (wr_accept),
        .wr_addr(RAM_AW'({wr_buf_q, wr_addr_q})),
        .wr_data(wr_data),
        .rd_en  (rd_issue),
        .rd_addr(RAM_AW'({rd_buf_q, rd_addr_q})),
        .rd_data(rd_data)
    );

    assign wr_frame_done = wr_frame_done_q;
    assign rd_valid      = rd_valid_q;
    assign rd_last       = rd_last_q;
    assign full_cnt      = full_cnt_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_frame_buf_ring.sv
// Directed bench for frame_buf_ring: a two-buffer instance and a single-buffer instance, scoreboarded reads.
module tb_frame_buf_ring;

    localparam int FW = 8;

    logic        wr_clk = 1'b0;
    logic        reset  = 1'b1;

    // two-buffer instance
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data  = '0;
    logic        rd_req   = 1'b0;
    logic        wr_ready, wr_frame_done, rd_avail, rd_valid, rd_last, ovf;
    logic [31:0] rd_data;
    logic [1:0]  full_cnt;

    // single-buffer instance
    logic        w1_valid = 1'b0;
    logic [31:0] w1_data  = '0;
    logic        r1_req   = 1'b0;
    logic        w1_ready, w1_done, r1_avail, r1_valid, r1_last, ovf1;
    logic [31:0] r1_data;
    logic [1:0]  f1_cnt;

    int errors = 0;
    int checks = 0;

    logic [32:0] exp_q[$];
    logic [32:0] exp1_q[$];

    always #5 wr_clk = ~wr_clk;

    frame_buf_ring #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .FRAME_WORDS(8), .NUM_BUFS(2)) dut (
        .wr_clk(wr_clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_frame_done(wr_frame_done), .rd_req(rd_req),
        .rd_avail(rd_avail), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .full_cnt(full_cnt), .ovf(ovf)
    );

    frame_buf_ring #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .FRAME_WORDS(8), .NUM_BUFS(1)) dut1 (
        .wr_clk(wr_clk), .reset(reset), .wr_valid(w1_valid), .wr_ready(w1_ready),
        .wr_data(w1_data), .wr_frame_done(w1_done), .rd_req(r1_req),
        .rd_avail(r1_avail), .rd_valid(r1_valid), .rd_data(r1_data), .rd_last(r1_last),
        .full_cnt(f1_cnt), .ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    // Scoreboards: every valid read word must match the oldest expected word.
    always @(negedge wr_clk) begin
        logic [32:0] e;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", rd_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", rd_data, e[31:0]);
                chk("rd_last", rd_last, e[32]);
            end
        end
        checks++;
        assert (full_cnt <= 2'd2) else begin
            errors++;
            $error("FAIL full_cnt_bound observed=%0d expected<=2", full_cnt);
        end
    end

    always @(negedge wr_clk) begin
        logic [32:0] e;
        if (r1_valid === 1'b1) begin
            if (exp1_q.size() == 0) begin
                chk("n1_rd_unexpected", r1_valid, 1'b0);
            end else begin
                e = exp1_q.pop_front();
                chk("n1_rd_data", r1_data, e[31:0]);
                chk("n1_rd_last", r1_last, e[32]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic write_words(input logic [31:0] base, input int first, input int n, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            int budget = 300;
            bit done   = 1'b0;
            wr_data = base + 32'(i);
            while (!done && budget > 0) begin
                wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (wr_valid && wr_ready) done = 1'b1;
                tick();
                budget--;
            end
            chk("wr_accept", done, 1'b1);
            if (done) begin
                exp_q.push_back({(i == FW - 1), base + 32'(i)});
                chk("wr_frame_done", wr_frame_done, (i == FW - 1));
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic read_words(input int n, input bit gaps);
        int budget = 300;
        int issued = 0;
        while (!rd_avail && budget > 0) begin
            tick();
            budget--;
        end
        chk("rd_avail_wait", rd_avail, 1'b1);
        while (issued < n && budget > 0) begin
            rd_req = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            if (rd_req) issued++;
            budget--;
        end
        rd_req = 1'b0;
        chk("rd_issue_count", issued, n);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 1'b1);
        chk({tag, "_frame_done"}, wr_frame_done, 1'b0);
        chk({tag, "_rd_avail"}, rd_avail, 1'b0);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_rd_last"}, rd_last, 1'b0);
        chk({tag, "_rd_data"}, rd_data, 32'h0);
        chk({tag, "_full_cnt"}, full_cnt, 2'd0);
        chk({tag, "_ovf"}, ovf, 1'b0);
    endtask

    initial begin
        // reset
        reset = 1'b1;
        tick();
        tick();
        chk_reset_values("reset");
        reset = 1'b0;
        tick();

        // single frame
        write_words(32'h10, 0, FW, 1'b0);
        chk("single_full_cnt", full_cnt, 2'd1);
        chk("single_rd_avail", rd_avail, 1'b1);
        read_words(FW, 1'b0);
        chk("single_full_cnt_after", full_cnt, 2'd0);
        chk("single_rd_avail_after", rd_avail, 1'b0);
        tick();
        chk("single_drained", exp_q.size(), 0);

        // fill to full, then overflow attempt
        write_words(32'h20, 0, FW, 1'b0);
        write_words(32'h30, 0, FW, 1'b0);
        chk("full_wr_ready", wr_ready, 1'b0);
        chk("full_full_cnt", full_cnt, 2'd2);
        chk("full_ovf_before", ovf, 1'b0);
        wr_valid = 1'b1;
        wr_data  = 32'h40;
        tick();
        tick();
        chk("full_ovf", ovf, 1'b1);
        chk("full_still_stalled", wr_ready, 1'b0);
        fork
            write_words(32'h40, 0, FW, 1'b0);
            begin
                read_words(FW - 1, 1'b0);
                chk("ready_before_release", wr_ready, 1'b0);
                read_words(1, 1'b0);
                chk("ready_after_release", wr_ready, 1'b1);
            end
        join
        read_words(FW, 1'b0);
        read_words(FW, 1'b0);
        chk("full_cnt_after_drain", full_cnt, 2'd0);

        // concurrent streaming with random gaps on both sides
        write_words(32'h50, 0, FW, 1'b0);
        fork
            write_words(32'h60, 0, FW, 1'b1);
            read_words(FW, 1'b1);
        join
        read_words(FW, 1'b1);
        tick();
        chk("stream_drained", exp_q.size(), 0);

        // simultaneous commit of B and release of A
        write_words(32'h70, 0, FW, 1'b0);
        write_words(32'h80, 0, FW - 1, 1'b0);
        read_words(FW - 1, 1'b0);
        chk("simul_full_cnt_before", full_cnt, 2'd1);
        wr_valid = 1'b1;
        wr_data  = 32'h87;
        rd_req   = 1'b1;
        exp_q.push_back({1'b1, 32'h87});
        tick();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        chk("simul_full_cnt", full_cnt, 2'd1);
        chk("simul_frame_done", wr_frame_done, 1'b1);
        chk("simul_rd_last", rd_last, 1'b1);
        read_words(1, 1'b0);
        @(negedge wr_clk);
        chk("simul_b_word0", rd_data, 32'h80);
        read_words(FW - 1, 1'b0);
        tick();

        // mid-frame reset
        write_words(32'h90, 0, FW, 1'b0);
        write_words(32'hA0, 0, 3, 1'b0);
        read_words(2, 1'b0);
        reset = 1'b1;
        tick();
        exp_q.delete();
        chk_reset_values("midreset");
        reset = 1'b0;
        tick();
        write_words(32'hB0, 0, FW, 1'b0);
        read_words(1, 1'b0);
        @(negedge wr_clk);
        chk("midreset_word0", rd_data, 32'hB0);
        read_words(FW - 1, 1'b0);
        tick();
        chk("midreset_drained", exp_q.size(), 0);

        // single-buffer instance: strict alternation
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FW; i++) begin
                w1_valid = 1'b1;
                w1_data  = 32'hC0 + 32'(f * 16 + i);
                chk("n1_wr_ready", w1_ready, 1'b1);
                exp1_q.push_back({(i == FW - 1), w1_data});
                tick();
            end
            w1_valid = 1'b0;
            chk("n1_frame_done", w1_done, 1'b1);
            chk("n1_ready_after_commit", w1_ready, 1'b0);
            chk("n1_rd_avail", r1_avail, 1'b1);
            r1_req = 1'b1;
            for (int i = 0; i < FW; i++) begin
                chk("n1_ready_low", w1_ready, 1'b0);
                tick();
            end
            r1_req = 1'b0;
            chk("n1_ready_after_release", w1_ready, 1'b1);
            chk("n1_full_cnt", f1_cnt, 2'd0);
        end
        tick();
        tick();
        chk("n1_drained", exp1_q.size(), 0);
        chk("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_buf_ring.md
# frame_buf_ring

Parametrised multi-buffer frame store in the `wr_clk` domain. It holds up to `NUM_BUFS` complete frames of `FRAME_WORDS` words in a ring of RAM banks. A producer fills the buffers in ring order and a consumer drains them in the same order. It replaces single-buffer frame storage with decoupled, back-pressured, multi-frame buffering between the capture and display paths.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 3, per-buffer word address width.
- `FRAME_WORDS`, `1 << ADDR_WIDTH`, words per frame; legal range 1..`2**ADDR_WIDTH`.
- `NUM_BUFS`, 2, number of frame buffers; ≥1.
- `BUF_W`, `max(1, $clog2(NUM_BUFS))`, derived buffer-index width.
- `wr_clk`  in  1  sole clock; both sides run on it.
- `reset`  in  1  reset, synchronous, active-high; clock `wr_clk`.
- `wr_valid`  in  1  producer word valid.
- `wr_ready`  out  1  buffer space available; word accepted when `wr_valid && wr_ready`.
- `wr_data`  in  `DATA_WIDTH`  producer word.
- `wr_frame_done`  out  1  one-cycle pulse: last word of a frame accepted.
- `rd_req`  in  1  consumer requests one word per cycle while high.
- `rd_avail`  out  1  at least one committed frame is readable.
- `rd_valid`  out  1  `rd_data` valid.
- `rd_data`  out  `DATA_WIDTH`  read word.
- `rd_last`  out  1  qualifies the final word of a frame, together with `rd_valid`.
- `full_cnt`  out  `BUF_W+1`  committed, not fully issued frames.
- `ovf`  out  1  sticky: `wr_valid` seen while `wr_ready` low; cleared only by reset.

## Operation
- **Pointers:**
  - `wr_buf`/`wr_addr` mark the next write location.
  - `rd_buf`/`rd_addr` mark the next read location.
  - Buffer indices wrap `NUM_BUFS-1`→0.
  - Word addresses wrap `FRAME_WORDS-1`→0.
- **Write FSM:**
  - WR_IDLE (no partial frame) → WR_FILL on the first accepted word.
  - WR_FILL → WR_IDLE on acceptance of the word at `wr_addr == FRAME_WORDS-1`. That edge commits the frame: `wr_buf++`, `full_cnt++`, `wr_frame_done` pulses.
  - WR_IDLE → WR_STALL when `full_cnt == NUM_BUFS`.
  - WR_STALL → WR_IDLE when `full_cnt` drops below `NUM_BUFS`.
- **`wr_ready`:** high iff `full_cnt < NUM_BUFS`. The ring guarantees the fill buffer is never the buffer being read.
- **Read FSM:**
  - RD_IDLE → RD_READ when `rd_req && rd_avail`; the first read issues on that same edge.
  - In RD_READ, each cycle with `rd_req` high issues one read at `{rd_buf, rd_addr}` and increments `rd_addr`.
  - Issue of address `FRAME_WORDS-1` releases the buffer: `rd_buf++`, `full_cnt--`, return to RD_IDLE.
  - `rd_req` low holds the read address with no gaps in data order.
- **`rd_avail`:** equals `full_cnt != 0`.
- **Simultaneous commit and release:** `full_cnt` is unchanged and both pointers advance.
- **`NUM_BUFS == 1`:** strict alternation — full frame write, full frame read, repeat.
- **Reset:**
  - All pointers, `full_cnt`, and FSMs are cleared; `ovf` is cleared.
  - Any partial write or read frame is discarded. RAM contents are not cleared.
  - Reset values: `wr_ready=1`, `wr_frame_done=0`, `rd_avail=0`, `rd_valid=0`, `rd_last=0`, `rd_data=0`, `full_cnt=0`, `ovf=0`.

## Timing
- Write: word at edge E lands in RAM at E.
- Read latency: read issued at edge E gives `rd_valid`/`rd_data`/`rd_last` during the cycle after E. The outputs are registered.
- `rd_valid` is low in any cycle following an edge with no issued read. `rd_data` holds its last value.
- Commit-to-read: last write at E0 → `rd_avail` high after E0 → earliest issue at E1 → data after E1. There are no same-cycle RAM write/read collisions on one buffer.
- Release at E frees the buffer. The earliest producer write into it is E+1, after its final word has been read at E.
- `wr_ready` and `rd_avail` depend only on registered state; there is no combinational path from `wr_valid` or `rd_req`.

## Structure
- Package `frame_buf_pkg`:
  - write-state enum `wr_state_t` (WR_IDLE, WR_FILL, WR_STALL);
  - read-state enum `rd_state_t` (RD_IDLE, RD_READ);
  - helper function `buf_w(n)` returning `max(1, clog2(n))`.
- Sub-module `frame_bank_ram`: simple dual-port RAM, depth `NUM_BUFS*2**ADDR_WIDTH`, synchronous write, registered read, 1-cycle latency. Address = `{buf, addr}`.
- Top level holds both FSMs, the pointers, `full_cnt`, and the output registers.

## Test plan
- **Single frame:** `NUM_BUFS=2`, `FRAME_WORDS=8`. Write 0x10..0x17 back-to-back, then hold `rd_req`. Required: `wr_frame_done` pulses on the 8th accept; `full_cnt` goes 0→1; `rd_data` = 0x10..0x17 on 8 consecutive cycles; `rd_last` on 0x17; `full_cnt` returns to 0.
- **Fill to full:** write 3 frames with no reads. Required: `wr_ready` drops after the 2nd commit; `full_cnt=2`; `ovf=1` once `wr_valid` is held. Reading one frame raises `wr_ready` the cycle after release. The 3rd frame then reads back intact.
- **Concurrent streaming:** write frame B while reading frame A, with random `rd_req` gaps. Required: no reordering; each word appears exactly once; `full_cnt` never exceeds 2.
- **Simultaneous commit and release:** align the last write of frame B with the last read issue of frame A. Required: `full_cnt` is unchanged at 1; the next read returns B's word 0.
- **`NUM_BUFS=1`:** write and read two frames. Required: `wr_ready` is low from commit through release; data is correct for both frames.
- **Mid-frame reset:** assert `reset` after 3 write words and 2 read words. Required: all outputs take their reset values the next cycle; a fresh frame afterward reads back from word 0.
